// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: md_op encodings and the
// helper that sizes the latency counter from the configured cycle counts.
package md_pkg;

  localparam logic [3:0] MD_NOP   = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;

  // Counter width needed to hold the larger of the two latencies.
  function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
    int mx;
    mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return $clog2(mx + 1);
  endfunction

  localparam int MD_CNT_W_DEFAULT = md_cnt_width(5, 10);

endpackage

// File: rtl/md_arith.sv
// Combinational datapath of the multiply/divide unit. Produces the 64-bit
// {hi,lo} result for the op presented, plus a divide-by-zero flag.
// MDU_MADD_EN: when defined, codes MD_MADD/MD_MADDU accumulate into acc.
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [63:0] acc,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_mag_safe;
  logic [31:0] rt_safe;
  logic [31:0] sd_q_mag;
  logic [31:0] sd_r_mag;
  logic [31:0] sd_q;
  logic [31:0] sd_r;
  logic [31:0] ud_q;
  logic [31:0] ud_r;

  // Sign/zero-extended 64-bit products; low 64 bits are exact either way.
  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // instead of relying on simulator/synth overflow behaviour.
  assign a_mag      = rs[31] ? (32'd0 - rs) : rs;
  assign b_mag      = rt[31] ? (32'd0 - rt) : rt;
  assign div_zero   = (rt == 32'd0);
  assign b_mag_safe = div_zero ? 32'd1 : b_mag;
  assign rt_safe    = div_zero ? 32'd1 : rt;
  assign sd_q_mag   = a_mag / b_mag_safe;
  assign sd_r_mag   = a_mag % b_mag_safe;
  assign sd_q       = (rs[31] ^ rt[31]) ? (32'd0 - sd_q_mag) : sd_q_mag;
  assign sd_r       = rs[31] ? (32'd0 - sd_r_mag) : sd_r_mag;
  assign ud_q       = rs / rt_safe;
  assign ud_r       = rs % rt_safe;

`ifndef MDU_MADD_EN
  logic unused_acc;
  assign unused_acc = ^acc;
`endif

  // Result select by op; non-arithmetic codes yield zero (never latched).
  always_comb begin
    result = 64'd0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {sd_r, sd_q};
      MD_DIVU:  result = {ud_r, ud_q};
`ifdef MDU_MADD_EN
      MD_MADD:  result = acc + prod_s;
      MD_MADDU: result = acc + prod_u;
`endif
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// Holds the latency counter, pending result and HI/LO; arithmetic lives in
// md_arith. MDU_MADD_EN enables MADD/MADDU (codes 7/8), otherwise they are NOPs.
//
// Handshake: start is sampled on every rising edge; it is accepted only when
// busy=0 and is dropped silently otherwise. busy stays high for exactly the
// op latency; the cycle it falls, hi/lo already show the new result and a new
// start may be presented in that same cycle.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [63:0]      pending;
  logic [63:0]      arith_result;
  logic             div_zero;
  logic             accept;
  logic             is_mult;
  logic             is_div;

  md_arith u_arith (
    .op       (md_op),
    .rs       (rs_data),
    .rt       (rt_data),
    .acc      ({hi, lo}),
    .result   (arith_result),
    .div_zero (div_zero)
  );

  assign busy   = (cnt != '0);
  assign accept = start && !busy;

  // Classify the incoming op into multi-cycle multiply or divide classes.
  always_comb begin
    is_mult = 1'b0;
    is_div  = 1'b0;
    case (md_op)
      MD_MULT, MD_MULTU: is_mult = 1'b1;
      MD_DIV, MD_DIVU:   is_div  = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU: is_mult = 1'b1;
`endif
      default: ;
    endcase
  end

  // Counter, pending result and HI/LO: accept when idle, commit on 1->0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pending <= 64'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        hi <= pending[63:32];
        lo <= pending[31:0];
      end
    end else if (accept) begin
      if (is_mult) begin
        cnt     <= CNT_W'(MULT_CYCLES);
        pending <= arith_result;
      end else if (is_div) begin
        cnt     <= CNT_W'(DIV_CYCLES);
        // Divide by zero re-commits the current HI/LO, i.e. no visible write;
        // HI/LO cannot change while busy so this snapshot stays accurate.
        pending <= div_zero ? {hi, lo} : arith_result;
      end else if (md_op == MD_MTHI) begin
        hi <= rs_data;
      end else if (md_op == MD_MTLO) begin
        lo <= rs_data;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: directed vectors, expected completions queued by the
// driver and checked by a negedge monitor when busy falls.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  // {busy_len, hi, lo}
  logic [95:0] exp_q[$];
  int          run_len = 0;
  logic        prev_busy = 1'b0;

  md_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op   = op;
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    md_op   = 4'd0;
  endtask

  task automatic expect_done(input int len, input logic [31:0] h, input logic [31:0] l);
    exp_q.push_back({32'(len), h, l});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle_timeout: busy=%0b after %0d cycles", busy, n);
    end
  endtask

  // scoreboard monitor: compare on each busy falling edge
  always @(negedge clk) begin
    logic [95:0] e;
    if (busy === 1'b1) run_len++;
    if (prev_busy === 1'b1 && busy === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: hi=%h lo=%h len=%0d expected no completion", hi, lo, run_len);
      end else begin
        e = exp_q.pop_front();
        check("busy_len", 32'(run_len), e[95:64]);
        check("done_hi", hi, e[63:32]);
        check("done_lo", lo, e[31:0]);
      end
      run_len = 0;
    end
    prev_busy = busy;
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    md_op   = 4'd0;
    rs_data = 32'd0;
    rt_data = 32'd0;
    tick();
    tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b0;
    tick();

    // MULT / MULTU
    expect_done(5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    issue(4'd1, 32'hFFFFFFFE, 32'h00000003);
    wait_idle();
    expect_done(5, 32'h00000002, 32'hFFFFFFFA);
    issue(4'd2, 32'hFFFFFFFE, 32'h00000003);
    wait_idle();

    // DIV / DIVU including divide by zero and overflow corner
    expect_done(10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(4'd3, 32'hFFFFFFF9, 32'h00000002);
    wait_idle();
    expect_done(10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(4'd4, 32'h00000007, 32'h00000000);
    wait_idle();
    expect_done(10, 32'h00000000, 32'h80000000);
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();
    expect_done(10, 32'h00000002, 32'h0000000E);
    issue(4'd4, 32'd100, 32'd7);
    wait_idle();

    // MTLO / MTHI while idle
    issue(4'd6, 32'h12345678, 32'd0);
    check("mtlo_lo", lo, 32'h12345678);
    check("mtlo_hi", hi, 32'h00000002);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    issue(4'd5, 32'hCAFEBABE, 32'd0);
    check("mthi_hi", hi, 32'hCAFEBABE);
    check("mthi_busy", {31'd0, busy}, 32'd0);

    // MTHI during a MULT busy window is ignored
    expect_done(5, 32'h00000001, 32'h00000000);
    issue(4'd1, 32'h00010000, 32'h00010000);
    tick();
    issue(4'd5, 32'h0000DEAD, 32'd0);
    check("mthi_while_busy_hi", hi, 32'hCAFEBABE);
    wait_idle();

    // back-to-back MULTs
    expect_done(5, 32'h00000000, 32'd42);
    expect_done(5, 32'h00000000, 32'h00000001);
    issue(4'd1, 32'd6, 32'd7);
    wait_idle();
    issue(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("b2b_second_busy", {31'd0, busy}, 32'd1);
    wait_idle();

    // NOP codes do nothing
    issue(4'd0, 32'hFFFF0000, 32'd3);
    check("nop0_busy", {31'd0, busy}, 32'd0);
    issue(4'd9, 32'hFFFF0000, 32'd3);
    check("nop9_busy", {31'd0, busy}, 32'd0);
    issue(4'd15, 32'hFFFF0000, 32'd3);
    check("nop15_busy", {31'd0, busy}, 32'd0);
    check("nop_hi", hi, 32'h00000000);
    check("nop_lo", lo, 32'h00000001);

    // MADD / MADDU
    issue(4'd5, 32'h00000000, 32'd0);
    issue(4'd6, 32'hFFFFFFFF, 32'd0);
`ifdef MDU_MADD_EN
    expect_done(5, 32'h00000001, 32'h00000000);
    issue(4'd8, 32'd1, 32'd1);
    wait_idle();
    expect_done(5, 32'h00000000, 32'hFFFFFFFF);
    issue(4'd7, 32'hFFFFFFFF, 32'd1);
    wait_idle();
`else
    issue(4'd8, 32'd1, 32'd1);
    check("maddu_off_busy", {31'd0, busy}, 32'd0);
    issue(4'd7, 32'hFFFFFFFF, 32'd1);
    check("madd_off_busy", {31'd0, busy}, 32'd0);
    tick();
    check("madd_off_hi", hi, 32'h00000000);
    check("madd_off_lo", lo, 32'hFFFFFFFF);
`endif

    // reset on cycle 3 of a DIV aborts it
    expect_done(3, 32'h00000000, 32'h00000000);
    issue(4'd3, 32'd100, 32'd3);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("abort_late_hi", hi, 32'd0);
    check("abort_late_lo", lo, 32'd0);
    check("abort_late_busy", {31'd0, busy}, 32'd0);

    // final report
    tick();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the CPU's execute stage. It sits directly downstream of the operand selectors: it takes the forwarded rs/rt values and owns the architectural HI/LO registers. Multiplies and divides run as fixed-latency multi-cycle operations, with a busy flag that the hazard controller uses to stall. MTHI/MTLO writes complete in a single cycle.

## Interface
- MULT_CYCLES, default 5: cycles busy is held for MULT/MULTU/MADD/MADDU; must be ≥1.
- DIV_CYCLES, default 10: cycles busy is held for DIV/DIVU; must be ≥1.
- clk, input, 1: the only clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high.
- start, input, 1: issue the operation on md_op this cycle.
- md_op, input, 4: operation code, encodings given in Operation.
- rs_data, input, 32: operand A, the forwarded rs value.
- rt_data, input, 32: operand B, the forwarded rt value.
- busy, output, 1: a multi-cycle operation is in flight.
- hi, output, 32: committed HI register.
- lo, output, 32: committed LO register.

## Operation
- md_op encodings:
  - 0: NOP
  - 1: MULT
  - 2: MULTU
  - 3: DIV
  - 4: DIVU
  - 5: MTHI
  - 6: MTLO
  - 7: MADD
  - 8: MADDU
  - 9–15: NOP
- A start is accepted only when busy=0. A start while busy=1 is ignored entirely; the controller must stall on (start && md_op is multi-cycle) || busy.
- An accepted multi-cycle op latches its 64-bit result into a pending register. It loads the counter with MULT_CYCLES or DIV_CYCLES.
- busy is (counter != 0). The counter decrements by 1 each cycle. On the edge where it goes 1→0, {hi,lo} ← pending.
- MULT is signed 32×32→64 and MULTU is unsigned; the 64-bit product goes to HI (upper) and LO (lower).
- DIV is signed: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU is unsigned: LO = quotient, HI = remainder.
- Divide by zero (rt_data==0): the op still occupies DIV_CYCLES with busy=1, but HI/LO are not written at completion.
- MADD/MADDU compute {hi,lo} + product modulo 2^64, signed or unsigned product respectively. The {hi,lo} used is the value at the accept edge.
- MTHI/MTLO with busy=0: hi or lo ← rs_data at the next edge, and busy stays 0.
- hi and lo hold their old values for the entire busy window.
- Reset: counter=0, pending=0, hi=0, lo=0, busy=0. Reset in the middle of an operation aborts it and no HI/LO write occurs. Reset wins over a simultaneous start.

## Timing
- A start accepted at edge E gives busy=1 from after E through after edge E+N−1, i.e. N cycles, where N is the op's latency.
- busy=0 and the new hi/lo are visible in the same cycle, after edge E+N.
- A new start may be accepted in that same cycle, so there is no bubble between ops.
- MTHI/MTLO: the value is visible one cycle after the accept edge.
- busy, hi and lo are direct register outputs with no combinational path from the inputs.

## Configuration
- Macro MDU_MADD_EN.
- Defined: codes 7 and 8 perform MADD and MADDU, with MULT_CYCLES latency.
- Undefined: codes 7 and 8 are NOP. busy stays 0, hi/lo are unchanged, and no accumulate hardware is built.

## Structure
- Package md_pkg holds:
  - the md_op localparams (MD_NOP … MD_MADDU);
  - the counter width, $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- Sub-module md_arith: a combinational compute of the 64-bit pending result from op, rs, rt and {hi,lo}, plus a div-by-zero flag.
- md_unit holds only:
  - the counter;
  - the pending register;
  - the HI/LO registers;
  - the accept and commit logic.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003: busy for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU on the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (−7) / 2: busy for exactly 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 0 leaves hi/lo unchanged after 10 busy cycles.
- MTLO 0x12345678 while idle: lo=0x12345678 one cycle later with busy never high. An MTHI issued during a MULT busy window is ignored.
- A second MULT started in the cycle busy drops is accepted; two results appear 5 cycles apart with no gap.
- Reset asserted on cycle 3 of a DIV: busy=0, hi=lo=0 next cycle, and no late write.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADDU 1×1 gives hi=1, lo=0 after 5 cycles. Without the macro, the same op leaves hi=0, lo=0xFFFFFFFF and busy=0.
